// File: rtl/arm_cond_pkg.sv
// Shared types and constants for ARM conditional execution.
package arm_cond_pkg;

  typedef logic [3:0] flags_t;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_t;

endpackage

// File: rtl/cond_check.sv
// Combinational condition-code check: instruction cond field against NZCV.
module cond_check
  import arm_cond_pkg::*;
(
  input  logic [3:0] cond,
  input  flags_t     flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  // Decode the condition field into a single pass/fail bit.
  always_comb begin
    pass = 1'b0;
    case (cond_t'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution unit: NZCV register, latched pass/fail and write gating.
module cond_unit
  import arm_cond_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       eval,
  input  logic       flush,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  input  logic       pcs,
  input  logic       reg_w,
  input  logic       mem_w,
  input  logic       no_write,
  output logic       cond_ex,
  output logic       pc_src,
  output logic       reg_write,
  output logic       mem_write,
  output flags_t     flags,
  output logic       carry
);

  flags_t flags_q;
  logic   cond_ex_q;
  logic   pass;

  // Evaluation always sees the stored flags, so a same-cycle write is invisible to it.
  cond_check u_cond_check (
    .cond  (cond),
    .flags (flags_q),
    .pass  (pass)
  );

  // Latched pass/fail: flush clears, eval loads, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cond_ex_q <= 1'b0;
    end else if (flush) begin
      cond_ex_q <= 1'b0;
    end else if (eval) begin
      cond_ex_q <= pass;
    end
  end

  // Flag register: NZ and CV halves written independently, only by a passing instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (!flush && cond_ex_q) begin
      if (flag_w[1]) begin
        flags_q[FLAG_N] <= alu_flags[FLAG_N];
        flags_q[FLAG_Z] <= alu_flags[FLAG_Z];
      end
      if (flag_w[0]) begin
        flags_q[FLAG_C] <= alu_flags[FLAG_C];
        flags_q[FLAG_V] <= alu_flags[FLAG_V];
      end
    end
  end

  assign cond_ex   = cond_ex_q;
  assign pc_src    = pcs & cond_ex_q;
  assign reg_write = reg_w & cond_ex_q & ~no_write;
  assign mem_write = mem_w & cond_ex_q;
  assign flags     = flags_q;
  assign carry     = flags_q[FLAG_C];

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit with a behavioural reference model.
module tb_cond_unit;

  logic       clk;
  logic       rst_n;
  logic       eval;
  logic       flush;
  logic [3:0] cond;
  logic [3:0] alu_flags;
  logic [1:0] flag_w;
  logic       pcs;
  logic       reg_w;
  logic       mem_w;
  logic       no_write;
  logic       cond_ex;
  logic       pc_src;
  logic       reg_write;
  logic       mem_write;
  logic [3:0] flags;
  logic       carry;

  int total = 0;
  int bad   = 0;

  // Reference state
  logic [3:0] m_flags;
  logic       m_cex;

  cond_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .eval      (eval),
    .flush     (flush),
    .cond      (cond),
    .alu_flags (alu_flags),
    .flag_w    (flag_w),
    .pcs       (pcs),
    .reg_w     (reg_w),
    .mem_w     (mem_w),
    .no_write  (no_write),
    .cond_ex   (cond_ex),
    .pc_src    (pc_src),
    .reg_write (reg_write),
    .mem_write (mem_write),
    .flags     (flags),
    .carry     (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Condition pairs: odd codes are the negation of the even code below them.
  function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c >> 1)
      0: base = z;
      1: base = cy;
      2: base = n;
      3: base = v;
      4: base = cy && !z;
      5: base = (n == v);
      6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'd14) return 1'b1;
    if (c == 4'd15) return 1'b0;
    return base ^ c[0];
  endfunction

  task automatic idle();
    eval = 0; flush = 0; cond = 4'd0; alu_flags = 4'd0; flag_w = 2'd0;
    pcs = 0; reg_w = 0; mem_w = 0; no_write = 0;
  endtask

  // Advance the model by one clock using the currently driven inputs, then clock the DUT.
  task automatic tick();
    logic       n_cex;
    logic [3:0] n_flags;
    n_cex   = flush ? 1'b0 : (eval ? ref_pass(cond, m_flags) : m_cex);
    n_flags = m_flags;
    if (!flush && m_cex) begin
      if (flag_w[1]) n_flags[3:2] = alu_flags[3:2];
      if (flag_w[0]) n_flags[1:0] = alu_flags[1:0];
    end
    @(posedge clk);
    #1;
    m_cex   = n_cex;
    m_flags = n_flags;
  endtask

  task automatic model_reset();
    m_flags = 4'd0;
    m_cex   = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    pcs = 1; reg_w = 1; mem_w = 1;
    rst_n = 0;
    model_reset();
    #3;
    total++;
    if ({pc_src, reg_write, mem_write} !== 3'b000) begin
      bad++; $display("FAIL reset_gates got=%b want=000", {pc_src, reg_write, mem_write});
    end
    total++;
    if (flags !== 4'b0000 || carry !== 1'b0 || cond_ex !== 1'b0) begin
      bad++; $display("FAIL reset_state flags=%b carry=%b cex=%b want 0000/0/0", flags, carry, cond_ex);
    end
    @(posedge clk); #2;
    rst_n = 1;
    @(posedge clk); #1;
    total++;
    if (reg_write !== 1'b0) begin
      bad++; $display("FAIL reset_release_gate got=%b want=0", reg_write);
    end
    eval = 1; cond = 4'b1110;
    tick();
    eval = 0;
    #1;
    total++;
    if (reg_write !== 1'b1 || cond_ex !== 1'b1) begin
      bad++; $display("FAIL reset_al_eval reg_write=%b cex=%b want 1/1", reg_write, cond_ex);
    end
    idle();
  endtask

  task automatic test_flag_write();
    flag_w = 2'b11; alu_flags = 4'b0110;
    tick();
    idle();
    total++;
    if (flags !== 4'b0110 || carry !== 1'b1) begin
      bad++; $display("FAIL flag_write flags=%b carry=%b want 0110/1", flags, carry);
    end
    eval = 1; cond = 4'b0000;
    tick();
    idle();
    total++;
    if (cond_ex !== 1'b1) begin
      bad++; $display("FAIL flag_write_eq cex=%b want 1", cond_ex);
    end
  endtask

  task automatic test_split_write();
    // Stored 0110 with cond_ex=1; write NZ only from 1001
    flag_w = 2'b10; alu_flags = 4'b1001;
    tick();
    idle();
    total++;
    if (flags !== 4'b1010) begin
      bad++; $display("FAIL split_write flags=%b want 1010", flags);
    end
    // N=1, V=0: GE fails, LT passes, GT fails
    eval = 1; cond = 4'b1010; tick(); idle();
    total++;
    if (cond_ex !== 1'b0) begin
      bad++; $display("FAIL split_ge cex=%b want 0", cond_ex);
    end
    eval = 1; cond = 4'b1011; tick(); idle();
    total++;
    if (cond_ex !== 1'b1) begin
      bad++; $display("FAIL split_lt cex=%b want 1", cond_ex);
    end
    eval = 1; cond = 4'b1100; tick(); idle();
    total++;
    if (cond_ex !== 1'b0) begin
      bad++; $display("FAIL split_gt cex=%b want 0", cond_ex);
    end
  endtask

  task automatic test_failed_instr();
    eval = 1; cond = 4'b1110; tick(); idle();
    flag_w = 2'b11; alu_flags = 4'b0000; tick(); idle();
    eval = 1; cond = 4'b0000; tick(); idle();
    total++;
    if (cond_ex !== 1'b0 || flags !== 4'b0000) begin
      bad++; $display("FAIL failed_eq cex=%b flags=%b want 0/0000", cond_ex, flags);
    end
    flag_w = 2'b11; alu_flags = 4'b1111; mem_w = 1;
    #1;
    total++;
    if (mem_write !== 1'b0) begin
      bad++; $display("FAIL failed_mem_write got=%b want=0", mem_write);
    end
    tick(); idle();
    total++;
    if (flags !== 4'b0000) begin
      bad++; $display("FAIL failed_flags_held got=%b want=0000", flags);
    end
  endtask

  task automatic test_simultaneous();
    eval = 1; cond = 4'b1110; tick(); idle();
    eval = 1; cond = 4'b0001; flag_w = 2'b10; alu_flags = 4'b0100;
    tick(); idle();
    total++;
    if (flags[2] !== 1'b1 || cond_ex !== 1'b1) begin
      bad++; $display("FAIL simultaneous z=%b cex=%b want 1/1", flags[2], cond_ex);
    end
  endtask

  task automatic test_flush();
    eval = 1; cond = 4'b1110; flush = 1; tick(); idle();
    total++;
    if (cond_ex !== 1'b0) begin
      bad++; $display("FAIL flush_eval cex=%b want 0", cond_ex);
    end
    eval = 1; cond = 4'b1110; tick(); idle();
    flush = 1; flag_w = 2'b11; alu_flags = ~m_flags; tick(); idle();
    total++;
    if (cond_ex !== 1'b0 || flags !== m_flags) begin
      bad++; $display("FAIL flush_flag_w cex=%b flags=%b want 0/%b", cond_ex, flags, m_flags);
    end
  endtask

  task automatic test_reset_mid();
    eval = 1; cond = 4'b1110; tick(); idle();
    flag_w = 2'b11; alu_flags = 4'b1111; pcs = 1;
    #2;
    rst_n = 0;
    model_reset();
    #1;
    total++;
    if (flags !== 4'b0000 || cond_ex !== 1'b0 || pc_src !== 1'b0) begin
      bad++; $display("FAIL reset_mid flags=%b cex=%b pc_src=%b want 0000/0/0", flags, cond_ex, pc_src);
    end
    @(posedge clk); #1;
    total++;
    if (flags !== 4'b0000) begin
      bad++; $display("FAIL reset_mid_hold flags=%b want 0000", flags);
    end
    #2;
    rst_n = 1;
    idle();
  endtask

  task automatic test_sweep();
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        eval = 1; cond = 4'b1110; tick(); idle();
        flag_w = 2'b11; alu_flags = 4'(f); tick(); idle();
        eval = 1; cond = 4'(c); tick(); idle();
        total++;
        if (flags !== 4'(f) || cond_ex !== ref_pass(4'(c), 4'(f))) begin
          bad++;
          $display("FAIL sweep cond=%0d flags=%b cex=%b want flags=%b cex=%b",
                   c, flags, cond_ex, 4'(f), ref_pass(4'(c), 4'(f)));
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      eval      = ($urandom_range(0, 2) == 0);
      flush     = ($urandom_range(0, 9) == 0);
      cond      = 4'($urandom);
      alu_flags = 4'($urandom);
      flag_w    = 2'($urandom);
      pcs       = 1'($urandom);
      reg_w     = 1'($urandom);
      mem_w     = 1'($urandom);
      no_write  = 1'($urandom);
      #1;
      total++;
      if (pc_src !== (pcs & m_cex) || reg_write !== (reg_w & m_cex & ~no_write) ||
          mem_write !== (mem_w & m_cex)) begin
        bad++;
        $display("FAIL rand_gates i=%0d got=%b%b%b cex_model=%b", i, pc_src, reg_write, mem_write, m_cex);
      end
      tick();
      total++;
      if (cond_ex !== m_cex || flags !== m_flags || carry !== m_flags[1]) begin
        bad++;
        $display("FAIL rand_state i=%0d cex=%b flags=%b carry=%b want %b/%b/%b",
                 i, cond_ex, flags, carry, m_cex, m_flags, m_flags[1]);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    rst_n = 1;
    model_reset();
    #2;
    test_reset();
    test_flag_write();
    test_split_write();
    test_failed_instr();
    test_simultaneous();
    test_flush();
    test_reset_mid();
    test_sweep();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
